imem_line_server: RTL and testbench

- Line-granular instruction memory that answers iCache fill requests: the responder end of the MemRead/PCMem → MemLine/MemReady interface.
- Accepts one outstanding line read and returns the full line after a fixed programmable latency, with a one-cycle MemReady pulse.
- Has a word-write load port so the bench and boot logic can preload program images.

---
 rtl/imem_line_server_pkg.sv | 27 ++
 rtl/imem_line_array.sv | 41 ++++
 rtl/imem_line_server.sv | 102 ++++++++++
 tb/tb_imem_line_server.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_line_server_pkg.sv
// Shared word/line geometry and the line-server FSM encoding.
// The line index starts at the same OFFSET boundary the iCache uses.
package imem_line_server_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int ICACHE_LINE_SIZE = 128;
    localparam int WORDS_PER_LINE   = ICACHE_LINE_SIZE / WORD_SIZE;

    // addi x0, x0, 0
    localparam logic [WORD_SIZE-1:0] NOP = 32'h0000_0013;

    // Byte address fields: [OFFSET_LSB-1:0] byte-in-word, then word offset, then index.
    localparam int OFFSET_LSB = 2;
    localparam int OFFSET_W   = $clog2(WORDS_PER_LINE);
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0] line_t;

endpackage

// File: rtl/imem_line_array.sv
// Line storage: one word-write port, one whole-line registered read port.
// Latency: read data one edge after rd_en_i; no backpressure, both ports always accepted.
module imem_line_array
    import imem_line_server_pkg::*;
#(
    parameter int NUM_LINES = 256,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en_i,
    input  logic [IDX_W-1:0]            wr_idx_i,
    input  logic [OFFSET_W-1:0]         wr_word_i,
    input  logic [WORD_SIZE-1:0]        wr_dat_i,
    input  logic                        rd_en_i,
    input  logic [IDX_W-1:0]            rd_idx_i,
    output logic [ICACHE_LINE_SIZE-1:0] rd_dat_o
);

    line_t mem_q [NUM_LINES];
    line_t rd_dat_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i][wr_word_i] <= wr_dat_i;
        end
    end

    // Same-edge write and read of one line returns the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/imem_line_server.sv
// iCache fill responder: one outstanding line read, MemReady pulse with the line.
// Latency: MEM_LATENCY cycles from accept; no backpressure, requests in BUSY/RESP are ignored.
module imem_line_server
    import imem_line_server_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int NUM_LINES   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        MemRead,
    input  logic [WORD_SIZE-1:0]        PCMem,
    input  logic                        LoadEn,
    input  logic [WORD_SIZE-1:0]        LoadAddr,
    input  logic [WORD_SIZE-1:0]        LoadData,
    output logic [ICACHE_LINE_SIZE-1:0] MemLine,
    output logic                        MemReady,
    output logic                        MemBusy
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr_bits;

    assign req_idx = PCMem[INDEX_LSB +: IDX_W];

    // Byte-in-word bits, and upper bits that wrap modulo NUM_LINES.
    assign unused_addr_bits = ^{PCMem[INDEX_LSB-1:0], PCMem[WORD_SIZE-1:INDEX_LSB+IDX_W],
                                LoadAddr[OFFSET_LSB-1:0], LoadAddr[WORD_SIZE-1:INDEX_LSB+IDX_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (MemRead) begin
                    idx_d = req_idx;
                    cnt_d = LAT_M1;
                    // Single-cycle latency captures the line on the accept edge itself.
                    if (MEM_LATENCY == 1) begin
                        rd_en   = 1'b1;
                        rd_idx  = req_idx;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    rd_en   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    imem_line_array #(
        .NUM_LINES (NUM_LINES)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (LoadEn),
        .wr_idx_i  (LoadAddr[INDEX_LSB +: IDX_W]),
        .wr_word_i (LoadAddr[OFFSET_LSB +: OFFSET_W]),
        .wr_dat_i  (LoadData),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_idx),
        .rd_dat_o  (MemLine)
    );

    assign MemReady = (state_q == ST_RESP);
    assign MemBusy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_line_server.sv
// Bench for imem_line_server: a MEM_LATENCY=5 instance and a MEM_LATENCY=1 instance
// sharing clock, reset and preload bus; expected lines are queued at request time.
module tb_imem_line_server;
    import imem_line_server_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         LoadEn;
    logic [31:0]  LoadAddr, LoadData;
    logic         MemRead_a, MemRead_b;
    logic [31:0]  PCMem_a, PCMem_b;
    logic [127:0] MemLine_a, MemLine_b;
    logic         MemReady_a, MemReady_b, MemBusy_a, MemBusy_b;

    imem_line_server #(.MEM_LATENCY(5), .NUM_LINES(256)) dut_a (
        .clk(clk), .rst(rst), .MemRead(MemRead_a), .PCMem(PCMem_a),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .MemLine(MemLine_a), .MemReady(MemReady_a), .MemBusy(MemBusy_a)
    );

    imem_line_server #(.MEM_LATENCY(1), .NUM_LINES(256)) dut_b (
        .clk(clk), .rst(rst), .MemRead(MemRead_b), .PCMem(PCMem_b),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .MemLine(MemLine_b), .MemReady(MemReady_b), .MemBusy(MemBusy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0][31:0] model [256];
    logic [127:0]     q_a [$];
    logic [127:0]     q_b [$];
    int               pulses   [2] = '{0, 0};
    int               last_rdy [2] = '{0, 0};
    logic             prev_a = 1'b0;
    logic             prev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'(a[11:4]);
    endfunction

    // Response monitors: every MemReady pulse must be single-cycle and match the queue head.
    always @(negedge clk) begin
        if (MemReady_a) begin
            check("a_rdy_width", 128'(prev_a), 128'd0);
            check("a_rdy_expected", 128'(q_a.size() != 0), 128'd1);
            if (q_a.size() != 0) check("a_line", MemLine_a, q_a.pop_front());
            pulses[0]++;
            last_rdy[0] = cyc;
        end
        prev_a = MemReady_a;
    end

    always @(negedge clk) begin
        if (MemReady_b) begin
            check("b_rdy_width", 128'(prev_b), 128'd0);
            check("b_rdy_expected", 128'(q_b.size() != 0), 128'd1);
            if (q_b.size() != 0) check("b_line", MemLine_b, q_b.pop_front());
            pulses[1]++;
            last_rdy[1] = cyc;
        end
        prev_b = MemReady_b;
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        LoadEn   = 1'b1;
        LoadAddr = a;
        LoadData = d;
        model[line_of(a)][a[3:2]] = d;
        @(negedge clk);
        LoadEn = 1'b0;
    endtask

    task automatic req(input int s, input logic [31:0] a, output int acc, output int n0);
        @(negedge clk);
        n0 = pulses[s];
        if (s == 0) begin
            MemRead_a = 1'b1; PCMem_a = a; q_a.push_back(model[line_of(a)]);
        end else begin
            MemRead_b = 1'b1; PCMem_b = a; q_b.push_back(model[line_of(a)]);
        end
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_rdy(input int s, input int acc, input int n0, input int lat,
                            input string tag, input bit drop);
        for (int i = 0; i < 40 && pulses[s] == n0; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_pulse"}, 128'(pulses[s] - n0), 128'd1);
        check({tag, "_lat"}, 128'(last_rdy[s] - acc), 128'(lat - 1));
        if (drop) begin
            if (s == 0) MemRead_a = 1'b0; else MemRead_b = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n0, n1, first;
        logic [127:0] dropped;

        rst = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
        MemRead_a = 1'b0; MemRead_b = 1'b0; PCMem_a = '0; PCMem_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready_a", 128'(MemReady_a), 128'd0);
        check("rst_busy_a",  128'(MemBusy_a),  128'd0);
        check("rst_line_a",  MemLine_a,        128'd0);
        check("rst_ready_b", 128'(MemReady_b), 128'd0);
        check("rst_line_b",  MemLine_b,        128'd0);
        rst = 1'b1;

        for (int k = 0; k < 4; k++) load(32'h20 + 32'(4 * k), 32'h11111111 * 32'(k + 1));
        for (int k = 0; k < 4; k++) load(32'h40 + 32'(4 * k), 32'hA000_0000 + 32'(k));

        // Basic fill of line 2.
        req(0, 32'h24, acc, n0);
        wait_rdy(0, acc, n0, 5, "t1", 1'b1);
        check("t1_line_lit", MemLine_a, 128'h44444444_33333333_22222222_11111111);

        // Upper address bits wrap onto line 2.
        req(0, 32'h20 + 32'(256 * 16), acc, n0);
        wait_rdy(0, acc, n0, 5, "t2_wrap", 1'b1);

        // Address change and MemRead drop during BUSY do not affect the response.
        req(0, 32'h24, acc, n0);
        PCMem_a = 32'h40;
        MemRead_a = 1'b0;
        wait_rdy(0, acc, n0, 5, "t2_busy_chg", 1'b1);

        req(0, 32'h48, acc, n0);
        wait_rdy(0, acc, n0, 5, "t2_line4", 1'b1);

        // Back-to-back with MemRead held through RESP.
        req(0, 32'h2C, acc, n0);
        q_a.push_back(model[2]);
        wait_rdy(0, acc, n0, 5, "t3_first", 1'b0);
        first = last_rdy[0];
        n1 = pulses[0];
        wait_rdy(0, first + 2, n1, 5, "t3_second", 1'b1);
        check("t3_spacing", 128'(last_rdy[0] - first), 128'd6);

        // Preload on the capture edge: captured line holds old word 0.
        req(0, 32'h20, acc, n0);
        repeat (2) @(negedge clk);
        load(32'h20, 32'hDEADBEEF);
        wait_rdy(0, acc, n0, 5, "t4_collide", 1'b1);
        check("t4_w0_old", 128'(MemLine_a[31:0]), 128'h11111111);
        req(0, 32'h20, acc, n0);
        wait_rdy(0, acc, n0, 5, "t4_after", 1'b1);
        check("t4_w0_new", 128'(MemLine_a[31:0]), 128'hDEADBEEF);

        // Asynchronous reset mid-BUSY aborts the transfer.
        req(0, 32'h40, acc, n0);
        @(negedge clk);
        check("t5_busy_before", 128'(MemBusy_a), 128'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_busy_rst",  128'(MemBusy_a),  128'd0);
        check("t5_ready_rst", 128'(MemReady_a), 128'd0);
        check("t5_line_rst",  MemLine_a,        128'd0);
        dropped = q_a.pop_back();
        MemRead_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_pulse", 128'(pulses[0] - n0), 128'd0);
        req(0, 32'h44, acc, n0);
        wait_rdy(0, acc, n0, 5, "t5_fresh", 1'b1);

        // Single-cycle latency instance.
        req(1, 32'h24, acc, n0);
        wait_rdy(1, acc, n0, 1, "t6_lat1", 1'b1);
        req(1, 32'h4C, acc, n0);
        wait_rdy(1, acc, n0, 1, "t6_lat1_l4", 1'b1);

        repeat (5) @(negedge clk);
        check("q_a_empty", 128'(q_a.size()), 128'd0);
        check("q_b_empty", 128'(q_b.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
